// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage.
//   XLEN_DEFAULT  : default PC / address width
//   INSTR_NOP     : canonical NOP (addi x0, x0, 0) used for misaligned targets
//   fetch_entry_t : one fetch-queue entry {pc, instr, misalign}
// -----------------------------------------------------------------------------
package if_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [31:0]             instr;
      logic                    misalign;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the redirect, instruction-memory and decode-side signals of the
// fetch stage. Signal suffixes are written from the fetch unit's viewpoint.
//   master : the fetch unit
//   slave  : its environment (core control, instruction memory, decode)
//
// Handshakes:
//   imem : a request transfers in a cycle where imem_req_o && imem_gnt_i;
//          once raised, imem_req_o/imem_addr_o stay put until granted unless a
//          redirect intervenes. Responses (imem_rvalid_i) come back in request
//          order, one per cycle at most, and cannot be back-pressured.
//   id   : the head entry transfers in a cycle where id_valid_o && id_ready_i;
//          id_pc_o/id_instr_o/id_misalign_o are stable while valid && !ready.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if
   import if_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            redirect_i;
   logic [XLEN-1:0] redirect_addr_i;
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic            id_valid_o;
   logic            id_ready_i;
   logic [XLEN-1:0] id_pc_o;
   logic [31:0]     id_instr_o;
   logic            id_misalign_o;

   modport master (
      input  redirect_i, redirect_addr_i, imem_gnt_i, imem_rvalid_i,
             imem_rdata_i, id_ready_i,
      output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o,
             id_misalign_o
   );

   modport slave (
      output redirect_i, redirect_addr_i, imem_gnt_i, imem_rvalid_i,
             imem_rdata_i, id_ready_i,
      input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o,
             id_misalign_o
   );

endinterface

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_fifo
// Registered FIFO of fetch entries; one push and one pop per cycle.
//   clk, rst       : clock, asynchronous active-high reset
//   flush_i        : empty the queue; a push in the same cycle becomes the
//                    sole surviving entry
//   push_i, data_i : write an entry
//   pop_i          : drop the head entry (only when not empty)
//   data_o         : head entry (meaningful only when !empty_o)
//   count_o        : occupancy, full_o / empty_o status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  T                       data_i,
   output T                       data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   T                mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   wr_addr;

   // A flushing push lands in slot 0, which is where rd_ptr restarts.
   assign wr_addr = flush_i ? '0 : wr_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = push_i ? AW'(1) : '0;
         count_d  = push_i ? (AW+1)'(1) : '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read until count says it was written.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_addr] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (int'(count_q) == DEPTH);
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: issues sequential fetches to an in-order
// request/grant memory port, queues returned words and hands {pc, instr} to
// decode. Redirects flush the queue and drop responses still in flight.
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : if_fetch_unit_if.master (redirect, imem_*, id_* signals)
// Optional build macro IF_MISALIGN_CHECK_EN: a redirect to a target with
// addr[1:0] != 0 halts fetching and queues a single NOP marked misaligned
// until the next redirect. Without it id_misalign_o is constant 0.
// -----------------------------------------------------------------------------
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int              XLEN            = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
   parameter int              QDEPTH          = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input logic             clk,
   input logic             reset,
   if_fetch_unit_if.master bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            misalign;
   } entry_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
   logic [CW-1:0]   outst_q,    outst_d;
   logic [CW-1:0]   discard_q,  discard_d;
   logic            halt_q,     halt_d;

   logic [CW-1:0]   fifo_count;
   logic            fifo_full, fifo_empty;
   logic            fifo_push, fifo_pop, fifo_flush;
   entry_t          push_entry, head;

   logic            credit_ok, req, granted, pop_req;

   // Every queue slot is reserved at request time, so a response can always
   // be pushed without back-pressuring the memory.
   assign credit_ok = (int'(fifo_count) + int'(outst_q) < QDEPTH) &&
                      (int'(outst_q) < MAX_OUTSTANDING);
   assign req       = !reset && !bus.redirect_i && !halt_q && credit_ok;
   assign granted   = req && bus.imem_gnt_i;
   assign pop_req   = !fifo_empty && bus.id_ready_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      halt_d     = halt_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      fifo_pop   = pop_req;
      push_entry = '0;

      if (granted) fetch_pc_d = fetch_pc_q + XLEN'(4);

      if (granted && !bus.imem_rvalid_i)      outst_d = outst_q + CW'(1);
      else if (!granted && bus.imem_rvalid_i) outst_d = outst_q - CW'(1);

      if (bus.redirect_i) begin
         fifo_flush = 1'b1;
         fifo_pop   = 1'b0;
         fetch_pc_d = bus.redirect_addr_i;
         resp_pc_d  = bus.redirect_addr_i;
         // Everything still owed by the memory after this cycle is stale,
         // including the word (if any) arriving right now.
         discard_d  = outst_d;
`ifdef IF_MISALIGN_CHECK_EN
         halt_d = (bus.redirect_addr_i[1:0] != 2'b00);
         if (halt_d) begin
            fifo_push           = 1'b1;
            push_entry.pc       = bus.redirect_addr_i;
            push_entry.instr    = INSTR_NOP;
            push_entry.misalign = 1'b1;
         end
`endif
      end else if (bus.imem_rvalid_i) begin
         if (discard_q != '0) begin
            discard_d = discard_q - CW'(1);
         end else begin
            fifo_push        = 1'b1;
            push_entry.pc    = resp_pc_q;
            push_entry.instr = bus.imem_rdata_i;
            resp_pc_d        = resp_pc_q + XLEN'(4);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_VECTOR;
         resp_pc_q  <= RESET_VECTOR;
         outst_q    <= '0;
         discard_q  <= '0;
         halt_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         halt_q     <= halt_d;
      end
   end

   if_fetch_fifo #(
      .DEPTH (QDEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (push_entry),
      .data_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   overflow_chk: assert property (@(posedge clk) disable iff (reset)
      (fifo_push && fifo_full) |-> (fifo_pop || fifo_flush));

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = fetch_pc_q;
   assign bus.id_valid_o    = !fifo_empty;
   assign bus.id_pc_o       = fifo_empty ? '0 : head.pc;
   assign bus.id_instr_o    = fifo_empty ? '0 : head.instr;
   assign bus.id_misalign_o = fifo_empty ? 1'b0 : head.misalign;

endmodule
